// File: rtl/compute_beta_s.sv
// compute_beta_s
// Backward (beta) state-metric recursion for the 8-state max-log-MAP turbo
// decoder. On an accepted start it reads the stored branch metrics from
// index N-1 down to 0, one per cycle, and emits one normalized set of eight
// beta metrics per cycle, tagged with its trellis index k (N first, 0 last).
//
// Ports
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   start               one-cycle request, honoured only in IDLE with blk_len != 0
//   blk_len, term       block length N and termination flag, sampled with start
//   bm_rd, bm_addr      branch-metric read strobe and address
//   m00..m11            signed branch metrics, valid the cycle after bm_rd
//   beta0..beta7        registered, normalized, saturated state metrics
//   beta_valid,beta_idx betas valid this cycle, and their trellis index
//   busy, done          recursion in progress, one-cycle completion pulse
//
// state | meaning
// IDLE  | waiting for start with a non-zero block length
// RUN   | presenting beta_N .. beta_0, one index per cycle
// DONE  | one-cycle completion pulse, then back to IDLE
module compute_beta_s #(
  parameter int ADDR_W = 13
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [ADDR_W-1:0]        blk_len,
  input  logic                     term,
  output logic                     bm_rd,
  output logic [ADDR_W-1:0]        bm_addr,
  input  logic signed [15:0]       m00,
  input  logic signed [15:0]       m01,
  input  logic signed [15:0]       m10,
  input  logic signed [15:0]       m11,
  output logic signed [15:0]       beta0,
  output logic signed [15:0]       beta1,
  output logic signed [15:0]       beta2,
  output logic signed [15:0]       beta3,
  output logic signed [15:0]       beta4,
  output logic signed [15:0]       beta5,
  output logic signed [15:0]       beta6,
  output logic signed [15:0]       beta7,
  output logic                     beta_valid,
  output logic [ADDR_W-1:0]        beta_idx,
  output logic                     busy,
  output logic                     done
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [ADDR_W-1:0] ONE = ADDR_W'(1);
  localparam logic signed [15:0] NEG_HALF_MAX = -16'sd32767;

  state_t                  state_q, state_d;
  logic [ADDR_W-1:0]       rd_left_q, rd_left_d;   // reads still to issue after the current cycle
  logic [ADDR_W-1:0]       idx_q, idx_d;
  logic signed [15:0]      beta_q [8];
  logic signed [15:0]      beta_d [8];

  logic signed [16:0]      sum_a [8];
  logic signed [16:0]      sum_b [8];
  logic signed [16:0]      raw [8];
  logic signed [17:0]      diff [8];
  logic signed [15:0]      beta_rec [8];
  logic                    accept;

  function automatic logic signed [16:0] sx17(input logic signed [15:0] v);
    return {v[15], v};
  endfunction

  function automatic logic signed [17:0] sx18(input logic signed [16:0] v);
    return {v[16], v};
  endfunction

  function automatic logic signed [15:0] sat16(input logic signed [17:0] v);
    if (v > 18'sd32767)
      return 16'sh7fff;
    else if (v < -18'sd32768)
      return 16'sh8000;
    else
      return v[15:0];
  endfunction

  // One trellis step: add-compare-select, then normalize against raw beta0.
  always_comb begin
    sum_a[0] = sx17(beta_q[0]) + sx17(m00);  sum_b[0] = sx17(beta_q[4]) + sx17(m11);
    sum_a[1] = sx17(beta_q[0]) + sx17(m11);  sum_b[1] = sx17(beta_q[4]) + sx17(m00);
    sum_a[2] = sx17(beta_q[1]) + sx17(m10);  sum_b[2] = sx17(beta_q[5]) + sx17(m01);
    sum_a[3] = sx17(beta_q[1]) + sx17(m01);  sum_b[3] = sx17(beta_q[5]) + sx17(m10);
    sum_a[4] = sx17(beta_q[2]) + sx17(m01);  sum_b[4] = sx17(beta_q[6]) + sx17(m10);
    sum_a[5] = sx17(beta_q[2]) + sx17(m10);  sum_b[5] = sx17(beta_q[6]) + sx17(m01);
    sum_a[6] = sx17(beta_q[3]) + sx17(m11);  sum_b[6] = sx17(beta_q[7]) + sx17(m00);
    sum_a[7] = sx17(beta_q[3]) + sx17(m00);  sum_b[7] = sx17(beta_q[7]) + sx17(m11);
    for (int i = 0; i < 8; i++) begin
      raw[i] = (sum_a[i] >= sum_b[i]) ? sum_a[i] : sum_b[i];
    end
    for (int i = 0; i < 8; i++) begin
      diff[i]     = sx18(raw[i]) - sx18(raw[0]);
      beta_rec[i] = sat16(diff[i]);
    end
  end

  assign accept = start && (blk_len != '0);

  always_comb begin
    state_d   = state_q;
    rd_left_d = rd_left_q;
    idx_d     = idx_q;
    for (int i = 0; i < 8; i++) beta_d[i] = beta_q[i];
    bm_rd     = 1'b0;
    bm_addr   = '0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          // First read goes out in the start cycle so metric N-1 lines up
          // with the first recursion step.
          bm_rd     = 1'b1;
          bm_addr   = blk_len - ONE;
          rd_left_d = blk_len - ONE;
          idx_d     = blk_len;
          beta_d[0] = '0;
          for (int i = 1; i < 8; i++) beta_d[i] = term ? NEG_HALF_MAX : 16'sd0;
          state_d   = RUN;
        end
      end
      RUN: begin
        if (rd_left_q != '0) begin
          bm_rd     = 1'b1;
          bm_addr   = rd_left_q - ONE;
          rd_left_d = rd_left_q - ONE;
        end
        if (idx_q == '0) begin
          state_d = DONE;
        end else begin
          idx_d = idx_q - ONE;
          for (int i = 0; i < 8; i++) beta_d[i] = beta_rec[i];
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      rd_left_q <= '0;
      idx_q     <= '0;
      for (int i = 0; i < 8; i++) beta_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      rd_left_q <= rd_left_d;
      idx_q     <= idx_d;
      for (int i = 0; i < 8; i++) beta_q[i] <= beta_d[i];
    end
  end

  assign beta0      = beta_q[0];
  assign beta1      = beta_q[1];
  assign beta2      = beta_q[2];
  assign beta3      = beta_q[3];
  assign beta4      = beta_q[4];
  assign beta5      = beta_q[5];
  assign beta6      = beta_q[6];
  assign beta7      = beta_q[7];
  assign beta_idx   = idx_q;
  assign beta_valid = (state_q == RUN);
  assign busy       = (state_q == RUN);
  assign done       = (state_q == DONE);

endmodule

// File: tb/tb_compute_beta_s.sv
// Self-checking bench for compute_beta_s: a reference model computes the
// whole beta sequence from the recursion equations when a block is started,
// and a negedge monitor checks reads, betas and done against the queues.
module tb_compute_beta_s;
  localparam int ADDR_W = 13;

  logic                clk = 1'b0;
  logic                rst = 1'b0;
  logic                start = 1'b0;
  logic [ADDR_W-1:0]   blk_len = '0;
  logic                term = 1'b0;
  logic                bm_rd;
  logic [ADDR_W-1:0]   bm_addr;
  logic signed [15:0]  m00 = '0, m01 = '0, m10 = '0, m11 = '0;
  logic signed [15:0]  beta0, beta1, beta2, beta3, beta4, beta5, beta6, beta7;
  logic                beta_valid;
  logic [ADDR_W-1:0]   beta_idx;
  logic                busy;
  logic                done;

  compute_beta_s #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .start(start), .blk_len(blk_len), .term(term),
    .bm_rd(bm_rd), .bm_addr(bm_addr),
    .m00(m00), .m01(m01), .m10(m10), .m11(m11),
    .beta0(beta0), .beta1(beta1), .beta2(beta2), .beta3(beta3),
    .beta4(beta4), .beta5(beta5), .beta6(beta6), .beta7(beta7),
    .beta_valid(beta_valid), .beta_idx(beta_idx), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Branch-metric store: [0]=m00 [1]=m01 [2]=m10 [3]=m11
  logic signed [15:0] mem [4][512];
  always @(posedge clk) begin
    if (bm_rd) begin
      m00 <= mem[0][bm_addr[8:0]];
      m01 <= mem[1][bm_addr[8:0]];
      m10 <= mem[2][bm_addr[8:0]];
      m11 <= mem[3][bm_addr[8:0]];
    end
  end

  int n_chk = 0;
  int n_fail = 0;

  int            exp_addr_q[$];
  int            exp_rd_cyc_q[$];
  int            exp_idx_q[$];
  int            exp_b_cyc_q[$];
  logic [127:0]  exp_b_q[$];
  int            exp_done_q[$];

  // Trellis connections: new state s = max(b[sa]+m[ma], b[sb]+m[mb])
  int sa[8] = '{0, 0, 1, 1, 2, 2, 3, 3};
  int ma[8] = '{0, 3, 2, 1, 1, 2, 3, 0};
  int sb[8] = '{4, 4, 5, 5, 6, 6, 7, 7};
  int mb[8] = '{3, 0, 1, 2, 2, 1, 0, 3};

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int clamp16(input int v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  function automatic logic [127:0] pack8(input int b[8]);
    logic [127:0] p;
    for (int i = 0; i < 8; i++) p[16*i +: 16] = b[i][15:0];
    return p;
  endfunction

  task automatic fill_mem(input int mode, input int n);
    for (int k = 0; k < n; k++)
      for (int q = 0; q < 4; q++)
        case (mode)
          0: mem[q][k] = '0;
          1: mem[q][k] = 16'($urandom);
          default: mem[q][k] = 16'(int'($urandom_range(400)) - 200);
        endcase
  endtask

  // Entered just after a rising edge; the start cycle t0 is the current one.
  task automatic issue_start(input int n, input bit t);
    int b[8];
    int nb[8];
    int mv[4];
    int x, y;
    int t0c;
    t0c = cyc;
    start = 1'b1;
    blk_len = n[ADDR_W-1:0];
    term = t;
    for (int j = 0; j < n; j++) begin
      exp_addr_q.push_back(n - 1 - j);
      exp_rd_cyc_q.push_back(t0c + j);
    end
    for (int s = 0; s < 8; s++) b[s] = (t && s != 0) ? -32767 : 0;
    exp_idx_q.push_back(n);
    exp_b_cyc_q.push_back(t0c + 1);
    exp_b_q.push_back(pack8(b));
    for (int k = n - 1; k >= 0; k--) begin
      for (int q = 0; q < 4; q++) mv[q] = int'(mem[q][k]);
      for (int s = 0; s < 8; s++) begin
        x = b[sa[s]] + mv[ma[s]];
        y = b[sb[s]] + mv[mb[s]];
        nb[s] = (x > y) ? x : y;
      end
      for (int s = 0; s < 8; s++) b[s] = clamp16(nb[s] - nb[0]);
      exp_idx_q.push_back(k);
      exp_b_cyc_q.push_back(t0c + 1 + n - k);
      exp_b_q.push_back(pack8(b));
    end
    exp_done_q.push_back(t0c + 2 + n);
    @(posedge clk); #1;
    start = 1'b0;
    blk_len = ADDR_W'($urandom);
    term = 1'($urandom);
  endtask

  function automatic int pending();
    return exp_addr_q.size() + exp_idx_q.size() + exp_done_q.size();
  endfunction

  task automatic wait_drain(input string name, input int budget);
    int i;
    i = 0;
    while (pending() != 0 && i < budget) begin
      @(posedge clk); #1;
      i++;
    end
    chk(name, 160'(pending()), 160'd0);
    exp_addr_q.delete(); exp_rd_cyc_q.delete();
    exp_idx_q.delete(); exp_b_cyc_q.delete(); exp_b_q.delete(); exp_done_q.delete();
  endtask

  function automatic logic [159:0] all_outs();
    return {2'b0, beta7, beta6, beta5, beta4, beta3, beta2, beta1, beta0,
            beta_valid, beta_idx, bm_rd, bm_addr, busy, done};
  endfunction

  // Monitor
  always @(negedge clk) begin
    if (!rst) begin
      if (bm_rd) begin
        if (exp_addr_q.size() == 0) begin
          chk("bm_rd_unexpected", 160'(bm_rd), 160'd0);
        end else begin
          chk("bm_addr", 160'(bm_addr), 160'(exp_addr_q.pop_front()));
          chk("bm_rd_cycle", 160'(cyc), 160'(exp_rd_cyc_q.pop_front()));
        end
      end
      if (beta_valid) begin
        if (exp_idx_q.size() == 0) begin
          chk("beta_valid_unexpected", 160'(beta_valid), 160'd0);
        end else begin
          chk("beta_idx", 160'(beta_idx), 160'(exp_idx_q.pop_front()));
          chk("beta_cycle", 160'(cyc), 160'(exp_b_cyc_q.pop_front()));
          chk("betas", 160'({beta7, beta6, beta5, beta4, beta3, beta2, beta1, beta0}),
              160'(exp_b_q.pop_front()));
          chk("busy_with_valid", 160'(busy), 160'd1);
        end
      end else if (exp_idx_q.size() != 0 && exp_b_cyc_q[0] <= cyc) begin
        chk("beta_valid_missing", 160'(beta_valid), 160'd1);
        void'(exp_idx_q.pop_front()); void'(exp_b_cyc_q.pop_front()); void'(exp_b_q.pop_front());
      end
      if (done) begin
        if (exp_done_q.size() == 0) begin
          chk("done_unexpected", 160'(done), 160'd0);
        end else begin
          chk("done_cycle", 160'(cyc), 160'(exp_done_q.pop_front()));
          chk("done_busy_valid", 160'({busy, beta_valid}), 160'd0);
        end
      end else if (exp_done_q.size() != 0 && exp_done_q[0] <= cyc) begin
        chk("done_missing", 160'(done), 160'd1);
        void'(exp_done_q.pop_front());
      end
    end
  end

  initial begin
    #1 rst = 1'b1;
    #1 chk("reset_values", all_outs(), 160'd0);
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    @(posedge clk); #1;

    // term=1, N=1, m00=100
    mem[0][0] = 16'sd100; mem[1][0] = '0; mem[2][0] = '0; mem[3][0] = '0;
    issue_start(1, 1'b1);
    wait_drain("drain_n1_term", 20);

    // term=0, N=1, m00=5 m11=3
    mem[0][0] = 16'sd5; mem[1][0] = '0; mem[2][0] = '0; mem[3][0] = 16'sd3;
    issue_start(1, 1'b0);
    wait_drain("drain_n1_unterm", 20);

    // term=0, N=300, all zero
    fill_mem(0, 300);
    issue_start(300, 1'b0);
    wait_drain("drain_n300", 400);

    // blk_len = 0 is ignored
    start = 1'b1; blk_len = '0; term = 1'b1;
    #1 chk("len0_no_read", 160'(bm_rd), 160'd0);
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1 chk("len0_idle", 160'({busy, beta_valid, done, bm_rd}), 160'd0);

    // start pulsed during RUN is ignored
    fill_mem(2, 20);
    issue_start(20, 1'b1);
    @(posedge clk); #1;
    start = 1'b1; blk_len = ADDR_W'(7); term = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    wait_drain("drain_start_in_run", 60);

    // Reset at t0+50 of an N=100 run, then a clean run
    fill_mem(1, 100);
    issue_start(100, 1'b1);
    repeat (49) @(posedge clk);
    #3 rst = 1'b1;
    #1 chk("reset_mid_run", all_outs(), 160'd0);
    exp_addr_q.delete(); exp_rd_cyc_q.delete();
    exp_idx_q.delete(); exp_b_cyc_q.delete(); exp_b_q.delete(); exp_done_q.delete();
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1 chk("after_reset_quiet", 160'({busy, beta_valid, done, bm_rd}), 160'd0);
    fill_mem(1, 100);
    issue_start(100, 1'b0);
    wait_drain("drain_after_reset", 200);

    // Randomized blocks
    for (int r = 0; r < 10; r++) begin
      int n;
      n = $urandom_range(60, 1);
      fill_mem(1 + (r % 2), n);
      issue_start(n, 1'($urandom));
      wait_drain("drain_random", n + 20);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not finish, failures so far %0d", n_fail);
    $fatal(1);
  end

endmodule

// File: doc/compute_beta_s.md
# compute_beta_s

Backward (beta) state-metric recursion for the 8-state max-log-MAP turbo decoder; it runs the opposite direction to the forward alpha recursion over the same trellis and branch metrics. On `start` it walks a stored block of branch metrics from index N-1 down to 0. It emits one normalized set of eight beta metrics per cycle, tagged with its trellis index, for the LLR stage.

## Interface
- `ADDR_W`, default 13: width of block length, metric address and index; N ranges over 1..2^ADDR_W-1.
- `clk`  in  1: sole clock, rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `start`  in  1: one-cycle request; sampled only in IDLE.
- `blk_len`  in  ADDR_W: block length N, sampled with `start`.
- `term`  in  1: sampled with `start`; 1 = trellis terminated in state 0, 0 = unterminated.
- `bm_rd`  out  1: branch-metric read strobe.
- `bm_addr`  out  ADDR_W: branch-metric read address.
- `m00`, `m01`, `m10`, `m11`  in  16 each: signed branch metrics, valid the cycle after `bm_rd`.
- `beta0` .. `beta7`  out  16 each: signed, registered state metrics.
- `beta_valid`  out  1: betas and `beta_idx` are valid this cycle.
- `beta_idx`  out  ADDR_W: trellis index k of the presented beta_k.
- `busy`  out  1: recursion in progress.
- `done`  out  1: one-cycle completion pulse.

## Operation
- FSM states: IDLE, RUN, DONE. IDLE goes to RUN on `start` with `blk_len` != 0. RUN goes to DONE after index 0 is presented. DONE goes to IDLE unconditionally.
- In IDLE, `start` with `blk_len` = 0 is ignored: no read, no output.
- In RUN, `start` is ignored.
- Initial metrics beta_N:
  - `term`=1: beta0 = 0, beta1..beta7 = -32767 (-MAX/2, MAX = 65535).
  - `term`=0: all eight = 0.
- Recursion: b' = beta_{k+1}, m = metrics of index k; max-log, no correction term.
  - beta0 = max(b0+m00, b4+m11); beta1 = max(b0+m11, b4+m00)
  - beta2 = max(b1+m10, b5+m01); beta3 = max(b1+m01, b5+m10)
  - beta4 = max(b2+m01, b6+m10); beta5 = max(b2+m10, b6+m01)
  - beta6 = max(b3+m11, b7+m00); beta7 = max(b3+m00, b7+m11)
- Width rules:
  - Sums are 17-bit signed.
  - Normalization subtracts raw beta0 from all eight, computed in 18 bits.
  - Results saturate to [-32768, 32767].
  - Consequently beta0 = 0 for every index below N.
- Read order: `bm_addr` = N-1, N-2, ..., 0, one per cycle. Each address is read exactly once.

## Timing
- Reset values: `beta0`..`beta7` = 0, `beta_valid` = 0, `beta_idx` = 0, `bm_rd` = 0, `bm_addr` = 0, `busy` = 0, `done` = 0; FSM in IDLE.
- t0 is the cycle in which `start` is sampled in IDLE.
- Reads:
  - `bm_rd` is high on cycles t0 .. t0+N-1, with `bm_addr` = N-1-j at cycle t0+j.
  - On cycle t0 the strobe is combinational from `start`; afterwards it comes from the down-counter.
- Outputs:
  - t0+1: `beta_valid` = 1, `beta_idx` = N, init metrics.
  - Cycle t0+1+N-k: beta_k, for every k, with no bubbles.
  - So index 0 appears at t0+1+N.
  - Latency from metric arrival to its beta is 1 cycle.
- `busy` is high t0+1 .. t0+1+N.
- t0+2+N: `done` = 1 for one cycle; `busy` = 0 and `beta_valid` = 0.
- `beta0`..`beta7` and `beta_idx` hold their last values while `beta_valid` = 0.
- The earliest accepted next `start` is at t0+3+N.
- Reset mid-run: every output returns to its reset value immediately; the FSM returns to IDLE. There is no `done` and no further reads.
- N = 1: read addr 0 at t0; idx 1 at t0+1; idx 0 at t0+2; `done` at t0+3.

## Test plan
- Reset: assert `rst` asynchronously mid-cycle -> all outputs 0 within the same cycle, with no clock edge needed.
- `term`=1, N=1, m00=100, others 0:
  - t0+1: idx 1 with (0, -32767 ×7).
  - t0+2: idx 0 = (0, -100, -32768, -32768, -32768, -32768, -32767, -32767).
  - `done` at t0+3.
- `term`=0, N=1, m00=5, m11=3, m01=m10=0 -> idx 0 = (0, 0, -5, -5, -5, -5, 0, 0).
- `term`=0, N=300, all metrics 0:
  - `bm_addr` runs 299..0 on t0..t0+299.
  - 301 consecutive valid cycles with idx 300..0, all betas 0.
  - `busy` spans t0+1..t0+301; `done` at t0+302.
- Protocol edges:
  - `start` with `blk_len`=0 -> no `bm_rd`, `busy`, or `done`.
  - `start` pulsed during RUN -> ignored; the sequence is unchanged.
- Reset at t0+50 of an N=100 run, then a new `start` -> clean run from idx N; no residual `bm_rd` or `done`.
